sr_cmd_gen: RTL and testbench
=============================

Name: sr_cmd_gen

Overview:
- Upstream command stage for the SR flip-flop.
- Takes two raw, bouncy, asynchronous pushbutton lines (set, clear) and converts them into clean one-cycle SR command codes on sr[1:0]. Encoding: 10 = set, 01 = reset, 00 = hold.
- Guarantees the forbidden code 11 is never driven; simultaneous requests are resolved by a fixed priority policy.
- Enforces a lockout gap between commands and tracks the expected flip-flop state.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a debounced level changes (legal range 1..255).
- LOCKOUT_CYCLES, 3, idle cycles forced after each issued command (legal range 0..255).
- PRIORITY, 0, simultaneous-request policy: 0 = drop both and flag conflict, 1 = set wins, 2 = clear wins.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- set_in  input  1  raw set button, asynchronous to clk.
- clr_in  input  1  raw clear button, asynchronous to clk.
- sr  output  2  command to SR flip-flop: sr[1] = set, sr[0] = reset; one-cycle pulse, otherwise 00.
- conflict  output  1  one-cycle pulse when simultaneous requests are dropped (PRIORITY = 0 only).
- busy  output  1  high while in LOCK state.
- q_model  output  1  expected flip-flop output: 1 after a set is issued, 0 after a clear is issued.

Behaviour:
- Reset (async, while rst high): all sync flops, debounced levels, counters and the pending register cleared; FSM = IDLE; sr = 00, conflict = 0, busy = 0, q_model = 0. Deasserting reset mid-command or mid-lockout discards the in-flight work; nothing is issued afterwards.
- Synchronizer: two-flop chain per input. The second stage (sync2) is the only value used downstream.
- Debounce, per channel:
  - An 8-bit counter increments each edge that sync2 differs from the debounced level, and clears whenever they match.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level takes sync2 and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Request: rising edge of a debounced level (deb & ~deb_prev) makes a one-cycle request. Falling edges are ignored.
- Arbitration, when both requests occur in the same cycle:
  - PRIORITY 0: both dropped, conflict pulses one cycle, no command.
  - PRIORITY 1: treated as set only.
  - PRIORITY 2: treated as clear only.
- FSM states: IDLE, LOCK.
  - IDLE, with a request or pending valid: register the command onto sr for exactly one cycle, update q_model on the same edge, load the lockout counter with LOCKOUT_CYCLES, go to LOCK. If LOCKOUT_CYCLES = 0, stay in IDLE.
  - Pending takes precedence over a new request. A new request arriving in the same cycle becomes the next pending.
  - LOCK: sr = 00, busy = 1, counter decrements each edge, return to IDLE when it reaches 0.
  - A request arriving during LOCK is stored in a one-deep pending register. A later request overwrites it (most recent wins). Arbitration applies before storage.
- Latency: set_in is first sampled high at edge 1 and held stable. sync2 goes high at edge 2, the debounced level at edge 2+DEBOUNCE_CYCLES, and sr = 10 is driven after edge 3+DEBOUNCE_CYCLES for one cycle.
- Redundant commands (set while q_model = 1) are still issued; q_model is unchanged.
- sr is fully registered with no combinational path from any input. sr == 11 is unreachable; the bench asserts this every cycle.

Test Plan:
- Reset then idle: rst high 2 cycles, inputs 0 for 20 cycles -> sr = 00, conflict = 0, busy = 0, q_model = 0 throughout.
- Clean set (defaults): set_in held high from edge 1 -> sr = 10 only in the cycle after edge 7; busy high for 3 cycles after that; q_model = 1 from edge 7.
- Bounce rejection: clr_in toggles every 2 cycles for 12 cycles, then stays 0 -> no command on sr. Then clr_in held high -> exactly one sr = 01 pulse, q_model = 0.
- Simultaneous: set_in and clr_in rise at the same edge. PRIORITY 0 -> conflict pulses once, sr stays 00. PRIORITY 1 -> one sr = 10. PRIORITY 2 -> one sr = 01.
- Lockout pending: a clear request lands during LOCK after a set -> sr = 01 in the first cycle after busy falls. Two requests during LOCK (clear then set) -> only sr = 10 is issued.
- Mid-operation reset: assert rst during LOCK with a pending command -> outputs zero immediately (asynchronously); no command after release; q_model = 0.

Source files
------------

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: turns two bouncy, asynchronous pushbuttons into clean one-cycle
// SR flip-flop commands. Each input is synchronized and debounced, then its
// rising edges become requests. Requests that arrive together are arbitrated.
// After each command a lockout gap follows, and a one-deep pending slot keeps
// the most recent request that arrived during that gap.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   set_in   - raw set button (asynchronous)
//   clr_in   - raw clear button (asynchronous)
//   sr[1:0]  - registered command pulse: 10 set, 01 reset, 00 hold (never 11)
//   conflict - one-cycle pulse when simultaneous requests are dropped (PRIORITY 0)
//   busy     - high while the lockout gap is running
//   q_model  - expected flip-flop state after the commands issued so far
module sr_cmd_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LOCKOUT_CYCLES  = 3,
    parameter int unsigned PRIORITY        = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_in,
    input  logic       clr_in,
    output logic [1:0] sr,
    output logic       conflict,
    output logic       busy,
    output logic       q_model
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES);
    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_CLR  = 2'b01;

    typedef enum logic {IDLE, LOCK} state_t;

    // Bit 1 carries the set channel and bit 0 the clear channel, which matches the sr encoding.
    logic [1:0]            sync1;
    logic [1:0]            sync2;
    logic [1:0]            deb;
    logic [1:0]            deb_prev;
    logic [1:0][CNT_W-1:0] deb_cnt;

    logic [1:0]       req;
    logic [1:0]       cmd;
    logic             drop;
    logic [1:0]       issue_cmd;

    state_t           state;
    logic [CNT_W-1:0] lock_cnt;
    logic [1:0]       pend;
    logic             pend_valid;

    // Two-flop synchronizers followed by per-channel debounce counters.
    // A level changes only when the counter would reach DEBOUNCE_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= {set_in, clr_in};
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A rising edge of a debounced level is a request; falling edges are ignored.
    assign req = deb & ~deb_prev;

    // Arbitration of simultaneous requests. A single request passes unchanged.
    always_comb begin
        cmd  = CMD_HOLD;
        drop = 1'b0;
        if (req == 2'b11) begin
            if (PRIORITY == 1) begin
                cmd = CMD_SET;
            end else if (PRIORITY == 2) begin
                cmd = CMD_CLR;
            end else begin
                drop = 1'b1;
            end
        end else begin
            cmd = req;
        end
    end

    // A pending command goes out before a new request.
    assign issue_cmd = pend_valid ? pend : cmd;

    // Command FSM. All outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            pend       <= CMD_HOLD;
            pend_valid <= 1'b0;
            sr         <= CMD_HOLD;
            conflict   <= 1'b0;
            busy       <= 1'b0;
            q_model    <= 1'b0;
        end else begin
            sr       <= CMD_HOLD;
            conflict <= drop;
            case (state)
                IDLE: begin
                    if (pend_valid || (cmd != CMD_HOLD)) begin
                        sr      <= issue_cmd;
                        q_model <= issue_cmd[1];
                        // When the pending command is issued, a new request takes its slot.
                        if (pend_valid) begin
                            pend       <= cmd;
                            pend_valid <= (cmd != CMD_HOLD);
                        end
                        if (LOCK_LOAD != '0) begin
                            state    <= LOCK;
                            busy     <= 1'b1;
                            lock_cnt <= LOCK_LOAD;
                        end
                    end
                end
                LOCK: begin
                    // The most recent request during the lockout gap wins.
                    if (cmd != CMD_HOLD) begin
                        pend       <= cmd;
                        pend_valid <= 1'b1;
                    end
                    if (lock_cnt == CNT_W'(1)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen. There are four instances: default (PRIORITY 0),
// PRIORITY 1, PRIORITY 2, and a long-lockout instance (LOCKOUT_CYCLES 12), so
// that two requests can land inside one lockout gap. k counts rising edges
// after the input change. Inputs are driven and outputs sampled 1 time unit
// after each rising edge.
module tb_sr_cmd_gen;

    logic clk = 1'b0;
    logic rst;
    logic set_in;
    logic clr_in;

    logic [1:0] sr0, sr1, sr2, sr3;
    logic       cf0, cf1, cf2, cf3;
    logic       bz0, bz1, bz2, bz3;
    logic       q0, q1, q2, q3;

    int tests = 0;
    int fails = 0;
    int bad11 = 0;

    always #5 clk = ~clk;

    sr_cmd_gen u0 (.clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
                   .sr(sr0), .conflict(cf0), .busy(bz0), .q_model(q0));
    sr_cmd_gen #(.PRIORITY(1)) u1 (.clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
                   .sr(sr1), .conflict(cf1), .busy(bz1), .q_model(q1));
    sr_cmd_gen #(.PRIORITY(2)) u2 (.clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
                   .sr(sr2), .conflict(cf2), .busy(bz2), .q_model(q2));
    sr_cmd_gen #(.LOCKOUT_CYCLES(12)) u3 (.clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
                   .sr(sr3), .conflict(cf3), .busy(bz3), .q_model(q3));

    // The forbidden code must never appear on any instance.
    always @(negedge clk) begin
        if (sr0 == 2'b11 || sr1 == 2'b11 || sr2 == 2'b11 || sr3 == 2'b11) bad11++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        set_in = 1'b0;
        clr_in = 1'b0;
        step();
        check("rst_state", 32'({sr0, cf0, bz0, q0, sr3, cf3, bz3, q3}), 32'd0);
        step();
        rst = 1'b0;

        // Reset then idle.
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("t1_idle_k%0d", k),
                  32'({sr0, cf0, bz0, q0, sr1, cf1, bz1, q1, sr2, cf2, bz2, q2}), 32'd0);
        end

        // Clean set: sr=10 after edge 7, busy for 3 cycles, q_model from edge 7.
        set_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t2_sr_k%0d", k), 32'(sr0), (k == 7) ? 32'd2 : 32'd0);
            check($sformatf("t2_busy_k%0d", k), 32'(bz0), (k >= 7 && k <= 9) ? 32'd1 : 32'd0);
            check($sformatf("t2_q_k%0d", k), 32'(q0), (k >= 7) ? 32'd1 : 32'd0);
            check($sformatf("t2_conf_k%0d", k), 32'(cf0), 32'd0);
        end
        set_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("t2_release_k%0d", k), 32'(sr0), 32'd0);
        end

        // Bounce rejection: 2-cycle runs never reach the debounce threshold.
        for (int i = 0; i < 12; i++) begin
            clr_in = (((i / 2) % 2) == 0);
            step();
            check($sformatf("t3_bounce_i%0d", i), 32'(sr0), 32'd0);
        end
        clr_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("t3_quiet_k%0d", k), 32'(sr0), 32'd0);
        end
        clr_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t3_sr_k%0d", k), 32'(sr0), (k == 7) ? 32'd1 : 32'd0);
            check($sformatf("t3_q_k%0d", k), 32'(q0), (k < 7) ? 32'd1 : 32'd0);
        end
        clr_in = 1'b0;
        repeat (20) step();

        // Simultaneous requests under all three policies.
        set_in = 1'b1;
        clr_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t4_p0_conf_k%0d", k), 32'(cf0), (k == 7) ? 32'd1 : 32'd0);
            check($sformatf("t4_p0_sr_k%0d", k), 32'(sr0), 32'd0);
            check($sformatf("t4_p0_q_k%0d", k), 32'(q0), 32'd0);
            check($sformatf("t4_p1_sr_k%0d", k), 32'(sr1), (k == 7) ? 32'd2 : 32'd0);
            check($sformatf("t4_p1_conf_k%0d", k), 32'(cf1), 32'd0);
            check($sformatf("t4_p1_q_k%0d", k), 32'(q1), (k >= 7) ? 32'd1 : 32'd0);
            check($sformatf("t4_p2_sr_k%0d", k), 32'(sr2), (k == 7) ? 32'd1 : 32'd0);
            check($sformatf("t4_p2_q_k%0d", k), 32'(q2), 32'd0);
        end
        set_in = 1'b0;
        clr_in = 1'b0;
        repeat (20) step();

        // Lockout pending: a clear request lands in LOCK after a set and is issued once IDLE.
        set_in = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("t5a_sr_k%0d", k), 32'(sr0),
                  (k == 7) ? 32'd2 : ((k == 11) ? 32'd1 : 32'd0));
            check($sformatf("t5a_busy_k%0d", k), 32'(bz0),
                  ((k >= 7 && k <= 9) || (k >= 11 && k <= 13)) ? 32'd1 : 32'd0);
            check($sformatf("t5a_q_k%0d", k), 32'(q0), (k >= 7 && k < 11) ? 32'd1 : 32'd0);
            if (k == 2) clr_in = 1'b1;
        end
        set_in = 1'b0;
        clr_in = 1'b0;
        repeat (40) step();

        // Clear, then set, both inside one long lockout gap: only the set is issued.
        set_in = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            check($sformatf("t5b_lk_sr_k%0d", k), 32'(sr3), (k == 7 || k == 20) ? 32'd2 : 32'd0);
            check($sformatf("t5b_lk_busy_k%0d", k), 32'(bz3),
                  ((k >= 7 && k <= 18) || k >= 20) ? 32'd1 : 32'd0);
            check($sformatf("t5b_lk_q_k%0d", k), 32'(q3), (k >= 7) ? 32'd1 : 32'd0);
            check($sformatf("t5b_d_sr_k%0d", k), 32'(sr0),
                  (k == 7 || k == 15) ? 32'd2 : ((k == 11) ? 32'd1 : 32'd0));
            check($sformatf("t5b_d_q_k%0d", k), 32'(q0),
                  ((k >= 7 && k < 11) || k >= 15) ? 32'd1 : 32'd0);
            if (k == 2) clr_in = 1'b1;
            if (k == 4) set_in = 1'b0;
            if (k == 8) set_in = 1'b1;
        end
        set_in = 1'b0;
        clr_in = 1'b0;
        repeat (40) step();

        // Mid-operation reset during LOCK with a pending clear.
        set_in = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 2) clr_in = 1'b1;
        end
        check("t6_pre_busy", 32'(bz0), 32'd1);
        check("t6_pre_q", 32'(q0), 32'd1);
        #1;
        rst    = 1'b1;
        set_in = 1'b0;
        clr_in = 1'b0;
        #1;
        check("t6_async_out", 32'({sr0, cf0, bz0, q0}), 32'd0);
        check("t6_async_lk", 32'({sr3, cf3, bz3, q3}), 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("t6_after_k%0d", k), 32'({sr0, cf0, bz0, q0, sr3, cf3, bz3, q3}), 32'd0);
        end

        check("never_11", 32'(bad11), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
